// File: rtl/cmp_sar_if.sv
// Comparator bus between the successive-approximation engine and an external
// combinational magnitude comparator.
//   probe   : value under test, driven by the engine (comparator operand b)
//   cmp_res : one-hot {lt, eq, gt} result of target vs probe
//             bit0 = target > probe, bit1 = equal, bit2 = target < probe
// master = engine side, slave = comparator side.
interface cmp_sar_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] probe;
  logic [2:0]       cmp_res;

  modport master (
    output probe,
    input  cmp_res
  );

  modport slave (
    input  probe,
    output cmp_res
  );
endinterface

// File: rtl/cmp_sar_search.sv
// Successive-approximation search engine. It drives a probe value into an
// external comparator and uses the {lt, eq, gt} answer to binary-search for
// an unknown target in the range 0 .. 2^WIDTH-1.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; outputs hold the last search outcome
//   SEARCH | one probe evaluated per cycle; exits on eq, bound or bad code
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : begin a search (only sampled in IDLE)
//   cmp        : comparator bus (probe out, cmp_res in)
//   busy       : high while searching
//   done       : one-cycle pulse in the first IDLE cycle after a search
//   result     : found target (0 on error), held until the next start
//   err        : search failed, held until the next start
//   steps      : number of probes evaluated in the last search
module cmp_sar_search #(
  parameter  int WIDTH = 4,
  localparam int SW    = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  cmp_sar_if.master        cmp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [SW-1:0]    steps
);

  typedef enum logic {
    ST_IDLE,
    ST_SEARCH
  } state_t;

  localparam logic [WIDTH:0]  B_ONE     = (WIDTH + 1)'(1);
  localparam logic [WIDTH:0]  B_MAX     = {1'b0, {WIDTH{1'b1}}};
  localparam logic [SW-1:0]   STEP_ONE  = SW'(1);
  // A well-behaved comparator always converges within WIDTH+1 probes;
  // anything longer means the comparator is lying.
  localparam logic [SW-1:0]   STEP_LAST = SW'(WIDTH + 1);

  localparam logic [2:0] RES_GT = 3'b001;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b100;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH:0]   lo_q, lo_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [SW-1:0]    steps_q, steps_d;

  // Bounds are one bit wider than the probe so probe+1 and lo+hi never wrap.
  logic [WIDTH:0]   probe_ext;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   sum_dn;
  logic             last_step;

  always_comb begin
    state_d   = state_q;
    probe_d   = probe_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    err_d     = err_q;
    steps_d   = steps_q;

    probe_ext = {1'b0, probe_q};
    sum_up    = probe_ext + B_ONE + hi_q;
    sum_dn    = lo_q + probe_ext - B_ONE;
    last_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          lo_d     = '0;
          hi_d     = B_MAX;
          probe_d  = B_MAX[WIDTH:1];
          steps_d  = '0;
          err_d    = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
          state_d  = ST_SEARCH;
        end
      end

      ST_SEARCH: begin
        steps_d   = steps_q + STEP_ONE;
        last_step = (steps_d == STEP_LAST);

        // Every exit path finishes the search; the branches below only
        // override what differs (result on success, err on failure) or
        // cancel the exit when the search narrows.
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;

        case (cmp.cmp_res)
          RES_EQ: begin
            result_d = probe_q;
          end

          RES_GT: begin
            if ((probe_ext == hi_q) || last_step) begin
              err_d    = 1'b1;
              result_d = '0;
            end else begin
              lo_d    = probe_ext + B_ONE;
              probe_d = sum_up[WIDTH:1];
              done_d  = 1'b0;
              busy_d  = 1'b1;
              state_d = ST_SEARCH;
            end
          end

          RES_LT: begin
            // probe == lo also guards probe-1 from underflowing at zero.
            if ((probe_ext == lo_q) || last_step) begin
              err_d    = 1'b1;
              result_d = '0;
            end else begin
              hi_d    = probe_ext - B_ONE;
              probe_d = sum_dn[WIDTH:1];
              done_d  = 1'b0;
              busy_d  = 1'b1;
              state_d = ST_SEARCH;
            end
          end

          default: begin
            err_d    = 1'b1;
            result_d = '0;
          end
        endcase
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      probe_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      steps_q  <= steps_d;
    end
  end

  assign cmp.probe = probe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign steps     = steps_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
module tb_cmp_sar_search;
  localparam int W     = 4;
  localparam int SW    = $clog2(W + 2);
  localparam int MAXV  = (1 << W) - 1;
  localparam int LIMIT = W + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic [SW-1:0] steps;

  int        target = 0;
  bit        force_en = 1'b0;
  logic [2:0] force_code = 3'b000;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int obs_q[$];
  int exp_res;
  bit exp_err;
  int exp_k;

  cmp_sar_if #(.WIDTH(W)) bus ();

  // Behavioural comparator: target is operand a, probe is operand b.
  always_comb begin
    if (force_en)                   bus.cmp_res = force_code;
    else if (target > int'(bus.probe))  bus.cmp_res = 3'b001;
    else if (target == int'(bus.probe)) bus.cmp_res = 3'b010;
    else                            bus.cmp_res = 3'b100;
  end

  cmp_sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp    (bus),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .steps  (steps)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain binary search over an integer interval, answering
  // each probe from the target (or from the forced comparator code).
  function automatic void model(input int tgt, input bit fen, input logic [2:0] fc);
    int lo, hi, p;
    bit stop;
    logic [2:0] code;
    lo = 0; hi = MAXV; p = MAXV / 2;
    exp_q.delete();
    exp_res = 0; exp_err = 1'b0; exp_k = 0; stop = 1'b0;
    for (int i = 0; i < 2 * LIMIT && !stop; i++) begin
      exp_k++;
      exp_q.push_back(p);
      if (fen)           code = fc;
      else if (tgt > p)  code = 3'b001;
      else if (tgt == p) code = 3'b010;
      else               code = 3'b100;
      if (code == 3'b010) begin
        exp_res = p; stop = 1'b1;
      end else if (code == 3'b001) begin
        if (p == hi || exp_k == LIMIT) begin exp_err = 1'b1; stop = 1'b1; end
        else begin lo = p + 1; p = (lo + hi) / 2; end
      end else if (code == 3'b100) begin
        if (p == lo || exp_k == LIMIT) begin exp_err = 1'b1; stop = 1'b1; end
        else begin hi = p - 1; p = (lo + hi) / 2; end
      end else begin
        exp_err = 1'b1; stop = 1'b1;
      end
    end
  endfunction

  // Runs one search. Returns at #1 after the edge that raised done, so the
  // caller is inside the done cycle (the IDLE cycle that can re-arm).
  task automatic run_search(input string name, input int tgt, input bit fen,
                            input logic [2:0] fc, input bit pulse, input bit hold);
    int  done_edge;
    bit  got;
    bit  seq_bad;
    model(tgt, fen, fc);
    obs_q.delete();
    done_edge = -1;
    got = 1'b0;
    @(negedge clk);
    target = tgt; force_en = fen; force_code = fc;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3 * LIMIT && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s arm: done=%b busy=%b, want done=0 busy=1", name, done, busy);
        end
        if (!hold) start = 1'b0;
      end
      if (pulse && c == 2) start = 1'b1;
      if (pulse && c == 3 && !hold) start = 1'b0;
      if (busy === 1'b1) obs_q.push_back(int'(bus.probe));
      @(posedge clk);
      #1;
      if (done === 1'b1) begin got = 1'b1; done_edge = c; end
    end
    if (!hold) start = 1'b0;

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, 3 * LIMIT);
    end

    seq_bad = (obs_q.size() != exp_q.size());
    for (int i = 0; i < obs_q.size() && !seq_bad; i++)
      if (obs_q[i] != exp_q[i]) seq_bad = 1'b1;
    checks++;
    if (seq_bad) begin
      errors++;
      $display("FAIL %s probes: got %p, want %p", name, obs_q, exp_q);
    end

    checks++;
    if (done_edge != exp_k) begin
      errors++;
      $display("FAIL %s latency: done %0d cycles after start, want %0d", name, done_edge + 1, exp_k + 1);
    end
    checks++;
    if (result !== exp_res[W-1:0]) begin
      errors++;
      $display("FAIL %s result: got %0d, want %0d", name, result, exp_res);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b, want %b", name, err, exp_err);
    end
    checks++;
    if (steps !== exp_k[SW-1:0]) begin
      errors++;
      $display("FAIL %s steps: got %0d, want %0d", name, steps, exp_k);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
    end
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if (bus.probe !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        result !== '0 || err !== 1'b0 || steps !== '0) begin
      errors++;
      $display("FAIL %s: probe=%0d busy=%b done=%b result=%0d err=%b steps=%0d, want all 0",
               name, bus.probe, busy, done, result, err, steps);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_idle_zero("reset_por");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_search("t7",  7,  1'b0, 3'b000, 1'b0, 1'b0);
    run_search("t15", 15, 1'b0, 3'b000, 1'b0, 1'b0);
    run_search("t0",  0,  1'b0, 3'b000, 1'b0, 1'b0);
    run_search("t9",  9,  1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_bad_comparator();
    run_search("all_gt",  3,  1'b1, 3'b001, 1'b0, 1'b0);
    run_search("all_lt",  3,  1'b1, 3'b100, 1'b0, 1'b0);
    run_search("code011", 5,  1'b1, 3'b011, 1'b0, 1'b0);
    run_search("code000", 5,  1'b1, 3'b000, 1'b0, 1'b0);
    run_search("code111", 5,  1'b1, 3'b111, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_search();
    run_search("pre_rst", 9, 1'b0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    target = 15; force_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero("reset_mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: done=%b in reset cycle %0d, want 0", done, i);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: done=%b busy=%b, want 0 0", done, busy);
    end
    run_search("post_rst", 15, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_search("pulse_t13", 13, 1'b0, 3'b000, 1'b1, 1'b0);
    run_search("pulse_t2",  2,  1'b0, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_search("b2b_0", 3,  1'b0, 3'b000, 1'b0, 1'b1);
    run_search("b2b_1", 12, 1'b0, 3'b000, 1'b0, 1'b1);
    run_search("b2b_2", 0,  1'b0, 3'b000, 1'b0, 1'b1);
    run_search("b2b_3", 15, 1'b0, 3'b000, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    logic [2:0] codes [6];
    int tgt;
    int r;
    bit fen;
    logic [2:0] fc;
    codes[0] = 3'b000; codes[1] = 3'b011; codes[2] = 3'b110;
    codes[3] = 3'b111; codes[4] = 3'b001; codes[5] = 3'b100;
    for (int n = 0; n < 30; n++) begin
      tgt = $urandom_range(0, MAXV);
      r   = $urandom_range(0, 9);
      fen = (r >= 7);
      fc  = codes[$urandom_range(0, 5)];
      run_search($sformatf("rand%0d", n), tgt, fen, fc, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_comparator();
    test_reset_mid_search();
    test_start_ignored();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
